// File: rtl/speech_pkg.sv
// Shared types and default sizes for the speech matching datapath.
// Holds the matcher FSM state encoding used by template_matcher.
package speech_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    COMPARE,
    DONE
  } match_state_t;

  localparam int SAMPLES_DEFAULT       = 1000;
  localparam int SAMPLE_W_DEFAULT      = 10;
  localparam int NUM_TEMPLATES_DEFAULT = 4;
  localparam int ACC_W_DEFAULT         = 20;

endpackage

// File: rtl/sad_accumulator.sv
// Saturating sum-of-absolute-differences accumulator.
// clear has priority over en; the sum sticks at all-ones instead of wrapping.
module sad_accumulator #(
  parameter int SAMPLE_W = 10,
  parameter int ACC_W    = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [ACC_W-1:0]    acc
);

  logic [SAMPLE_W-1:0] w_diff;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_next;
  logic [ACC_W-1:0]    r_acc;

  // unsigned |a-b| at sample width, then a one-bit-wider add to catch overflow
  always_comb begin
    w_diff = (a >= b) ? (a - b) : (b - a);
    w_sum  = {1'b0, r_acc}
           + {{(ACC_W + 1 - SAMPLE_W){1'b0}}, w_diff};
    w_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  end

  // accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_acc <= '0;
    else if (clear) r_acc <= '0;
    else if (en)    r_acc <= w_next;
  end

  assign acc = r_acc;

endmodule

// File: rtl/template_matcher.sv
// Scores a captured utterance against stored templates by SAD; reports best.
// Optional: TEMPLATE_MATCHER_REJECT_EN adds reject_thresh and gates match_valid.
module template_matcher
  import speech_pkg::*;
#(
  parameter int SAMPLES       = SAMPLES_DEFAULT,
  parameter int NUM_TEMPLATES = NUM_TEMPLATES_DEFAULT,
  parameter int SAMPLE_W      = SAMPLE_W_DEFAULT,
  parameter int ACC_W         = ACC_W_DEFAULT,
  localparam int AW = $clog2(SAMPLES),
  localparam int TW = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
`ifdef TEMPLATE_MATCHER_REJECT_EN
  input  logic [ACC_W-1:0]    reject_thresh,
`endif
  output logic [AW-1:0]       sample_addr,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic [TW-1:0]       tmpl_sel,
  output logic [AW-1:0]       tmpl_addr,
  input  logic [SAMPLE_W-1:0] tmpl_data,
  output logic                busy,
  output logic                done,
  output logic [TW-1:0]       match_idx,
  output logic [ACC_W-1:0]    match_score,
  output logic                match_valid
);

  match_state_t     r_state;
  logic [AW-1:0]    r_addr;
  logic [TW-1:0]    r_sel;
  logic             r_vld;
  logic [ACC_W-1:0] r_best;
  logic [TW-1:0]    r_best_idx;
  logic             r_busy;
  logic             r_done;
  logic [TW-1:0]    r_idx;
  logic [ACC_W-1:0] r_score;
  logic             r_valid;

  logic             w_start_ok;
  logic             w_clear;
  logic             w_last_addr;
  logic             w_last_sel;
  logic             w_pass;
  logic [ACC_W-1:0] w_acc;

  // decode: accepted start, accumulator clear, end-of-template markers
  always_comb begin
    w_start_ok  = (r_state == IDLE) && start;
    w_clear     = w_start_ok || (r_state == COMPARE);
    w_last_addr = (r_addr == AW'(SAMPLES - 1));
    w_last_sel  = (r_sel == TW'(NUM_TEMPLATES - 1));
`ifdef TEMPLATE_MATCHER_REJECT_EN
    w_pass      = (r_best <= reject_thresh);
`else
    w_pass      = 1'b1;
`endif
  end

  sad_accumulator #(
    .SAMPLE_W (SAMPLE_W),
    .ACC_W    (ACC_W)
  ) u_sad (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (r_vld),
    .a     (sample_data),
    .b     (tmpl_data),
    .acc   (w_acc)
  );

  // control FSM with address counter, best tracking and registered results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_sel      <= '0;
      r_vld      <= 1'b0;
      r_best     <= '1;
      r_best_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_score    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_vld  <= (r_state == RUN);
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_addr     <= '0;
            r_sel      <= '0;
            r_best     <= '1;
            r_best_idx <= '0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          if (w_last_addr) r_state <= DRAIN;
          else             r_addr  <= r_addr + 1'b1;
        end
        DRAIN: begin
          r_state <= COMPARE;
        end
        COMPARE: begin
          if (w_acc < r_best) begin
            r_best     <= w_acc;
            r_best_idx <= r_sel;
          end
          if (w_last_sel) begin
            r_state <= DONE;
          end else begin
            r_state <= RUN;
            r_sel   <= r_sel + 1'b1;
            r_addr  <= '0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_idx   <= r_best_idx;
          r_score <= r_best;
          r_valid <= w_pass;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sample_addr = r_addr;
  assign tmpl_addr   = r_addr;
  assign tmpl_sel    = r_sel;
  assign busy        = r_busy;
  assign done        = r_done;
  assign match_idx   = r_idx;
  assign match_score = r_score;
  assign match_valid = r_valid;

endmodule

// File: tb/tb_template_matcher.sv
// Bench for template_matcher with SAMPLES=8 (ACC_W=20 and a saturating ACC_W=10 copy).
// Table vectors, hand sequences and random data against an arithmetic SAD model.
module tb_template_matcher;

  localparam int S  = 8;
  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] rt = '1;

  logic [9:0] smp [S];
  logic [9:0] tpl [NT][S];

  logic [2:0]  a0, ta0, a1, ta1;
  logic [1:0]  sel0, sel1, idx0, idx1;
  logic [9:0]  sd0, td0, sd1, td1;
  logic        busy0, busy1, done0, done1, val0, val1;
  logic [19:0] sc0;
  logic [9:0]  sc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  template_matcher #(.SAMPLES(S), .NUM_TEMPLATES(NT)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef TEMPLATE_MATCHER_REJECT_EN
    .reject_thresh(rt),
`endif
    .sample_addr(a0), .sample_data(sd0),
    .tmpl_sel(sel0), .tmpl_addr(ta0), .tmpl_data(td0),
    .busy(busy0), .done(done0), .match_idx(idx0),
    .match_score(sc0), .match_valid(val0)
  );

  template_matcher #(.SAMPLES(S), .NUM_TEMPLATES(NT), .ACC_W(10)) dut_sat (
    .clk(clk), .reset(reset), .start(start),
`ifdef TEMPLATE_MATCHER_REJECT_EN
    .reject_thresh(rt[9:0]),
`endif
    .sample_addr(a1), .sample_data(sd1),
    .tmpl_sel(sel1), .tmpl_addr(ta1), .tmpl_data(td1),
    .busy(busy1), .done(done1), .match_idx(idx1),
    .match_score(sc1), .match_valid(val1)
  );

  // synchronous 1-cycle-latency memories
  always @(posedge clk) begin
    sd0 <= smp[a0];
    td0 <= tpl[sel0][ta0];
    sd1 <= smp[a1];
    td1 <= tpl[sel1][ta1];
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // SAD of every template, saturated to aw bits; best = minimum, lowest index on ties
  task automatic model(input int aw, output int idx, output int score);
    int sc [NT];
    int mx;
    mx = (1 << aw) - 1;
    for (int t = 0; t < NT; t++) begin
      int sum = 0;
      for (int i = 0; i < S; i++) begin
        int a = int'(smp[i]);
        int b = int'(tpl[t][i]);
        sum += (a > b) ? a - b : b - a;
      end
      sc[t] = (sum > mx) ? mx : sum;
    end
    score = sc[0];
    for (int t = 1; t < NT; t++) if (sc[t] < score) score = sc[t];
    idx = -1;
    for (int t = NT - 1; t >= 0; t--) if (sc[t] == score) idx = t;
  endtask

  task automatic fill(input int sv, input int t0, input int t1,
                      input int t2, input int t3);
    for (int i = 0; i < S; i++) begin
      smp[i]    = 10'(sv);
      tpl[0][i] = 10'(t0);
      tpl[1][i] = 10'(t1);
      tpl[2][i] = 10'(t2);
      tpl[3][i] = 10'(t3);
    end
  endtask

  task automatic do_run(input string tag, input int ei, input int es,
                        input int esi, input int ess, input int ev,
                        input int esv, input int reinject);
    int cyc;
    int extra;
    bit got;
    cyc = 0;
    got = 0;
    extra = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_busy_run"}, busy0, 1);
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == reinject) start = 1'b1;
      if (cyc == reinject + 1) start = 1'b0;
      if (done0) got = 1;
    end
    if (!got) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    check({tag, "_latency"}, cyc, NT * (S + 2) + 1);
    check({tag, "_sat_done"}, done1, 1);
    check({tag, "_busy_done"}, busy0, 0);
    check({tag, "_idx"}, idx0, ei);
    check({tag, "_score"}, sc0, es);
    check({tag, "_valid"}, val0, ev);
    check({tag, "_sat_idx"}, idx1, esi);
    check({tag, "_sat_score"}, sc1, ess);
    check({tag, "_sat_valid"}, val1, esv);
    @(posedge clk); #1;
    check({tag, "_pulse_width"}, done0, 0);
    repeat (40) begin
      @(posedge clk); #1;
      if (done0) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_held_idx"}, idx0, ei);
  endtask

  typedef struct {
    string nm;
    int sv;
    int t0, t1, t2, t3;
    int ei, es, esi, ess;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int ri, rs, rsi, rss;

    tbl[0] = '{"basic", 512, 500, 500, 512, 500, 2, 0, 2, 0};
    tbl[1] = '{"tie", 512, 522, 515, 502, 509, 1, 24, 1, 24};
    tbl[2] = '{"sat", 1023, 0, 0, 0, 0, 0, 8184, 0, 1023};
    tbl[3] = '{"idx3", 100, 200, 150, 120, 101, 3, 8, 3, 8};
    tbl[4] = '{"satmix", 0, 1023, 1023, 1023, 1000, 3, 8000, 0, 1023};

    fill(0, 0, 0, 0, 0);
    #12;
    check("rst_addr", a0, 0);
    check("rst_sel", sel0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_idx", idx0, 0);
    check("rst_score", sc0, 0);
    check("rst_valid", val0, 0);
    @(negedge clk); reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill(tbl[v].sv, tbl[v].t0, tbl[v].t1, tbl[v].t2, tbl[v].t3);
      do_run(tbl[v].nm, tbl[v].ei, tbl[v].es, tbl[v].esi, tbl[v].ess,
             1, 1, -5);
    end

    // second start during RUN must be ignored
    fill(512, 522, 515, 502, 509);
    do_run("proto", 1, 24, 1, 24, 1, 1, 5);

    // reset in mid-run, then a clean rerun
    fill(512, 500, 500, 512, 500);
    do_run("pre_rst", 2, 0, 2, 0, 1, 1, -5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mrst_addr", a0, 0);
    check("mrst_sel", sel0, 0);
    check("mrst_busy", busy0, 0);
    check("mrst_done", done0, 0);
    check("mrst_idx", idx0, 0);
    check("mrst_score", sc0, 0);
    check("mrst_valid", val0, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("mrst_idle_busy", busy0, 0);
    check("mrst_idle_done", done0, 0);
    do_run("post_rst", 2, 0, 2, 0, 1, 1, -5);

`ifdef TEMPLATE_MATCHER_REJECT_EN
    fill(512, 522, 515, 502, 509);
    rt = 20'd10;
    do_run("rej10", 1, 24, 1, 24, 0, 0, -5);
    rt = 20'd24;
    do_run("rej24", 1, 24, 1, 24, 1, 1, -5);
    rt = '1;
`endif

    // randomized data against the SAD model
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < S; i++) smp[i] = 10'($urandom_range(0, 1023));
      for (int t = 0; t < NT; t++) begin
        int nz = (n < 6) ? int'($urandom_range(0, 40)) : 1023;
        for (int i = 0; i < S; i++) begin
          int v = int'(smp[i]) + int'($urandom_range(0, 2 * nz)) - nz;
          tpl[t][i] = 10'((v < 0) ? 0 : (v > 1023) ? 1023 : v);
        end
      end
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < S; i++) tpl[3][i] = tpl[1][i];
      model(20, ri, rs);
      model(10, rsi, rss);
      do_run($sformatf("rnd%0d", n), ri, rs, rsi, rss, 1, 1, -5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
